strobe_gen_multi: RTL and testbench

STROBE_GEN_MULTI -- requirements
Module: strobe_gen_multi

---
 rtl/strobe_pkg.sv | 16 +
 rtl/strobe_gen_multi_if.sv | 29 ++
 rtl/strobe_single_ch.sv | 100 ++++++++++
 rtl/strobe_gen_multi.sv | 97 +++++++++
 tb/tb_strobe_gen_multi.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/strobe_pkg.sv
// Shared types and default sizing for the multi-channel strobe generator.
package strobe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int STROBE_NUM_CH   = 4;
    localparam int STROBE_CNT_W    = 16;
    localparam int STROBE_PRESC    = 24;
    localparam int STROBE_PERIOD_W = 28;

endpackage

// File: rtl/strobe_gen_multi_if.sv
// Lamp-control bundle between the host and the strobe generator.
interface strobe_gen_multi_if
    import strobe_pkg::*;
#(
    parameter int NUM_CH = STROBE_NUM_CH,
    parameter int CNT_W  = STROBE_CNT_W
);
    logic [NUM_CH-1:0] lamp_enable;
    logic [NUM_CH-1:0] single_trig;
    logic [CNT_W-1:0]  ss_high_delay;
    logic [CNT_W-1:0]  ss_low_delay;
    logic [CNT_W-1:0]  countbase;
    logic [CNT_W-1:0]  strbcount;
    logic [NUM_CH-1:0] single_strobe;
    logic [NUM_CH-1:0] single_busy;
    logic [NUM_CH-1:0] single_done;
    logic [NUM_CH-1:0] single_err;
    logic [NUM_CH-1:0] cont_strobe;

    modport master (
        output lamp_enable, single_trig, ss_high_delay, ss_low_delay, countbase, strbcount,
        input  single_strobe, single_busy, single_done, single_err, cont_strobe
    );

    modport slave (
        input  lamp_enable, single_trig, ss_high_delay, ss_low_delay, countbase, strbcount,
        output single_strobe, single_busy, single_done, single_err, cont_strobe
    );
endinterface

// File: rtl/strobe_single_ch.sv
// One lamp channel's single-strobe sequencer: IDLE -> WAIT -> LOW -> DONE -> IDLE,
// timed in prescaled ticks against delays latched at trigger time.
module strobe_single_ch
    import strobe_pkg::*;
#(
    parameter int CNT_W = STROBE_CNT_W,
    parameter int PRESC = STROBE_PRESC
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] high_delay_i,
    input  logic [CNT_W-1:0] low_delay_i,
    output logic             strobe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d, presc_nxt;
    logic [CNT_W-1:0] tick_q, tick_d, tick_nxt;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
    logic             err_q, err_d;
    logic             wrap;

    assign wrap      = (presc_q == PRESC_LAST);
    assign presc_nxt = wrap ? '0 : presc_q + PW'(1);
    assign tick_nxt  = wrap ? tick_q + CNT_W'(1) : tick_q;

    // Phase changes are decided on the tick value being written, so a delay of
    // N ticks lands exactly N*PRESC cycles after WAIT entry.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        high_d  = high_q;
        low_d   = low_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_i) begin
                    if (low_delay_i > high_delay_i) begin
                        if (enable_i) begin
                            state_d = WAIT;
                            presc_d = '0;
                            tick_d  = '0;
                            high_d  = high_delay_i;
                            low_d   = low_delay_i;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                presc_d = presc_nxt;
                tick_d  = tick_nxt;
                if (tick_nxt == high_q) state_d = LOW;
            end
            LOW: begin
                presc_d = presc_nxt;
                tick_d  = tick_nxt;
                if (tick_nxt == low_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n_i) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            high_q  <= '0;
            low_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            high_q  <= high_d;
            low_q   <= low_d;
            err_q   <= err_d;
        end
    end

    assign strobe_o = (state_q != LOW);
    assign busy_o   = (state_q == WAIT) || (state_q == LOW);
    assign done_o   = (state_q == DONE);
    assign err_o    = err_q;

endmodule

// File: rtl/strobe_gen_multi.sv
// Multi-channel lamp strobe generator: per-channel single strobes plus one shared
// continuous square wave gated per channel by lamp_enable.
module strobe_gen_multi
    import strobe_pkg::*;
#(
    parameter int NUM_CH   = STROBE_NUM_CH,
    parameter int CNT_W    = STROBE_CNT_W,
    parameter int PRESC    = STROBE_PRESC,
    parameter int PERIOD_W = STROBE_PERIOD_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    strobe_gen_multi_if.slave bus
);
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: reset asserts asynchronously but releases two edges later, so no flop
    // sees a reset edge racing the clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [NUM_CH-1:0] ss_w, busy_w, done_w, err_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        strobe_single_ch #(
            .CNT_W (CNT_W),
            .PRESC (PRESC)
        ) u_ch (
            .clk_i        (sys_clk),
            .rst_n_i      (rst_n),
            .enable_i     (bus.lamp_enable[g]),
            .trig_i       (bus.single_trig[g]),
            .high_delay_i (bus.ss_high_delay),
            .low_delay_i  (bus.ss_low_delay),
            .strobe_o     (ss_w[g]),
            .busy_o       (busy_w[g]),
            .done_o       (done_w[g]),
            .err_o        (err_w[g])
        );
    end

    assign bus.single_strobe = ss_w;
    assign bus.single_busy   = busy_w;
    assign bus.single_done   = done_w;
    assign bus.single_err    = err_w;

    logic [CNT_W-1:0]    cb_q, sc_q;
    logic [CNT_W:0]      mult;
    logic [2*CNT_W-1:0]  prod;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                param_chg;

    // Full-precision product before truncation so wide periods are not clipped early.
    assign mult      = {1'b0, bus.strbcount} + (CNT_W + 1)'(1);
    assign prod      = (2*CNT_W)'(bus.countbase[CNT_W-1:1]) * (2*CNT_W)'(mult);
    assign half_d    = PERIOD_W'(prod);
    assign param_chg = (bus.countbase != cb_q) || (bus.strbcount != sc_q);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (param_chg || (half_q == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == half_q - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_q    <= '0;
            sc_q    <= '0;
            half_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cb_q    <= bus.countbase;
            sc_q    <= bus.strbcount;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.cont_strobe = ~bus.lamp_enable | {NUM_CH{phase_q}};

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Directed and randomized checks of strobe_gen_multi against a timing model
// expressed as cycle offsets from trigger and parameter-change edges.
module tb_strobe_gen_multi;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int PRESC    = 24;
    localparam int PERIOD_W = 28;
    localparam int NEVER    = 32'h7fff_ffff;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int edge_n  = 0;

    // Single-strobe model: trigger edge, latched delays, abort edge, error edge.
    int t0[NUM_CH];
    int hd[NUM_CH];
    int ld[NUM_CH];
    int ab[NUM_CH];
    int err_at[NUM_CH];

    // Continuous model: edge of last parameter change and resulting half-period.
    int cc_edge = -1;
    int hh      = 0;
    int prev_cb = 0;
    int prev_sc = 0;

    int low_cnt;
    int first_low;
    int trig_edge;

    always #5 sys_clk = ~sys_clk;

    strobe_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    strobe_gen_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .PRESC    (PRESC),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    function automatic bit ch_idle(int c, int e);
        if (t0[c] < 0 || e >= ab[c]) return 1'b1;
        return (e - t0[c]) > PRESC * ld[c];
    endfunction

    task automatic step();
        @(posedge sys_clk);
        edge_n++;
        @(negedge sys_clk);
    endtask

    task automatic set_cont(int cb, int sc);
        bus.countbase = CNT_W'(cb);
        bus.strbcount = CNT_W'(sc);
        if (cb != prev_cb || sc != prev_sc) begin
            cc_edge = edge_n + 1;
            hh      = (cb / 2) * (sc + 1);
            prev_cb = cb;
            prev_sc = sc;
        end
    endtask

    task automatic set_en(logic [NUM_CH-1:0] en);
        for (int c = 0; c < NUM_CH; c++)
            if (bus.lamp_enable[c] && !en[c] && t0[c] >= 0 && ab[c] > edge_n + 1)
                ab[c] = edge_n + 1;
        bus.lamp_enable = en;
    endtask

    task automatic fire(logic [NUM_CH-1:0] mask, int hi, int lo);
        bus.single_trig   = mask;
        bus.ss_high_delay = CNT_W'(hi);
        bus.ss_low_delay  = CNT_W'(lo);
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c] && ch_idle(c, edge_n)) begin
                if (lo > hi) begin
                    if (bus.lamp_enable[c]) begin
                        t0[c] = edge_n + 1;
                        hd[c] = hi;
                        ld[c] = lo;
                        ab[c] = NEVER;
                    end
                end else begin
                    err_at[c] = edge_n + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] e_ss, e_busy, e_done, e_err, e_cont;
        logic ph;
        int k, ls, le;
        if (cc_edge < 0 || hh == 0) ph = 1'b1;
        else                        ph = (((edge_n - cc_edge) / hh) % 2) == 0;
        for (int c = 0; c < NUM_CH; c++) begin
            e_ss[c]   = 1'b1;
            e_busy[c] = 1'b0;
            e_done[c] = 1'b0;
            e_err[c]  = (edge_n == err_at[c]);
            if (t0[c] >= 0 && edge_n < ab[c]) begin
                k  = edge_n - t0[c];
                ls = (PRESC * hd[c] > 1) ? PRESC * hd[c] : 1;
                le = PRESC * ld[c];
                e_ss[c]   = !(k >= ls && k < le);
                e_busy[c] = (k < le);
                e_done[c] = (k == le);
            end
            e_cont[c] = bus.lamp_enable[c] ? ph : 1'b1;
        end
        n_total++;
        assert (bus.single_strobe === e_ss) n_pass++;
        else begin n_fail++; $error("FAIL single_strobe edge=%0d observed=%b expected=%b", edge_n, bus.single_strobe, e_ss); end
        n_total++;
        assert (bus.single_busy === e_busy) n_pass++;
        else begin n_fail++; $error("FAIL single_busy edge=%0d observed=%b expected=%b", edge_n, bus.single_busy, e_busy); end
        n_total++;
        assert (bus.single_done === e_done) n_pass++;
        else begin n_fail++; $error("FAIL single_done edge=%0d observed=%b expected=%b", edge_n, bus.single_done, e_done); end
        n_total++;
        assert (bus.single_err === e_err) n_pass++;
        else begin n_fail++; $error("FAIL single_err edge=%0d observed=%b expected=%b", edge_n, bus.single_err, e_err); end
        n_total++;
        assert (bus.cont_strobe === e_cont) n_pass++;
        else begin n_fail++; $error("FAIL cont_strobe edge=%0d observed=%b expected=%b", edge_n, bus.cont_strobe, e_cont); end
    endtask

    task automatic check_rst(string tag);
        n_total++;
        assert (bus.single_strobe === '1) n_pass++;
        else begin n_fail++; $error("FAIL %s single_strobe observed=%b expected=all ones", tag, bus.single_strobe); end
        n_total++;
        assert (bus.cont_strobe === '1) n_pass++;
        else begin n_fail++; $error("FAIL %s cont_strobe observed=%b expected=all ones", tag, bus.cont_strobe); end
        n_total++;
        assert ({bus.single_busy, bus.single_done, bus.single_err} === '0) n_pass++;
        else begin n_fail++; $error("FAIL %s busy/done/err observed=%b/%b/%b expected=0", tag, bus.single_busy, bus.single_done, bus.single_err); end
    endtask

    task automatic run(int n);
        repeat (n) begin
            step();
            check_all();
            bus.single_trig = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lamp_enable   = '0;
        bus.single_trig   = '0;
        bus.ss_high_delay = '0;
        bus.ss_low_delay  = '0;
        bus.countbase     = '0;
        bus.strbcount     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            t0[c] = -1; hd[c] = 0; ld[c] = 0; ab[c] = NEVER; err_at[c] = -1;
        end

        repeat (3) @(negedge sys_clk);
        check_rst("reset_hold");
        sys_rst_n = 1'b1;
        run(4);

        // Continuous wave: half-period 10, then 15 after a mid-period change.
        set_en('1);
        set_cont(10, 1);
        run(14);
        set_cont(10, 2);
        run(50);

        repeat (5) begin
            set_en(NUM_CH'($urandom));
            set_cont($urandom_range(0, 24), $urandom_range(0, 3));
            run(40);
        end

        set_en('1);
        set_cont(1, 0);
        run(60);
        set_cont(6, 0);

        // Channel 0 strobe with delays changed after the trigger.
        fire(4'b0001, 2, 5);
        trig_edge = edge_n + 1;
        low_cnt   = 0;
        first_low = -1;
        repeat (130) begin
            step();
            check_all();
            bus.single_trig   = '0;
            bus.ss_high_delay = CNT_W'(0);
            bus.ss_low_delay  = CNT_W'(1);
            if (!bus.single_strobe[0]) begin
                low_cnt++;
                if (first_low < 0) first_low = edge_n;
            end
        end
        n_total++;
        assert (low_cnt === 72) n_pass++;
        else begin n_fail++; $error("FAIL ch0_low_len observed=%0d expected=72", low_cnt); end
        n_total++;
        assert (first_low - trig_edge === 48) n_pass++;
        else begin n_fail++; $error("FAIL ch0_low_start observed=%0d expected=48", first_low - trig_edge); end

        // Rejected trigger: equal delays.
        fire(4'b0100, 5, 5);
        run(5);

        // Two channels, channel 1 disabled mid-LOW, ignored retrigger on channel 0.
        fire(4'b0011, 1, 4);
        run(40);
        set_en(4'b1101);
        run(10);
        fire(4'b0001, 0, 2);
        run(70);
        set_en('1);
        run(2);

        repeat (4) begin
            fire(NUM_CH'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 5));
            run(1);
            bus.ss_high_delay = CNT_W'($urandom);
            bus.ss_low_delay  = CNT_W'($urandom);
            run(150);
        end

        // Asynchronous reset while channel 0 is in LOW.
        fire(4'b0001, 0, 3);
        run(10);
        #2 sys_rst_n = 1'b0;
        #1 check_rst("reset_mid_low");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
